// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result bundle for pipelined_adder
// PIPE_ADDER_STALL_EN adds the out_ready/in_ready backpressure pair.
interface pipelined_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             negative;
  logic             zero;
`ifdef PIPE_ADDER_STALL_EN
  logic             out_ready;
  logic             in_ready;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  out_valid, result, carry_out, overflow, negative, zero, in_ready
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output out_valid, result, carry_out, overflow, negative, zero, in_ready
  );
`else
  modport master (
    output in_valid, a, b, sub,
    input  out_valid, result, carry_out, overflow, negative, zero
  );
  modport slave (
    input  in_valid, a, b, sub,
    output out_valid, result, carry_out, overflow, negative, zero
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep sliced ripple adder/subtractor with NZCV flags
// Optional backpressure (out_ready/in_ready) is built when PIPE_ADDER_STALL_EN is defined.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipelined_adder_if.slave  bus
);
  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic advance;

`ifdef PIPE_ADDER_STALL_EN
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
`else
  assign advance = 1'b1;
`endif

  // Each stage carries only the operand bits still to be added, so the skew
  // registers shrink by one slice per stage and results grow by one slice.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int INW = WIDTH - k * SW;

    logic [INW-1:0]        a_in;
    logic [INW-1:0]        b_in;
    logic                  c_in;
    logic                  v_in;
    logic [SW:0]           sum;
    logic [(k+1)*SW-1:0]   r_nx;
    logic [(k+1)*SW-1:0]   r_q;
    logic                  c_q;
    logic                  v_q;

    if (k == 0) begin : g_head
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.sub;
      assign v_in = bus.in_valid;
      assign r_nx = sum[SW-1:0];
    end else begin : g_link
      assign a_in = g_stage[k-1].g_skew.a_q;
      assign b_in = g_stage[k-1].g_skew.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign r_nx = {sum[SW-1:0], g_stage[k-1].r_q};
    end

    assign sum = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + (SW+1)'(c_in);

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= sum[SW];
        r_q <= r_nx;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [INW-SW-1:0] a_q;
      logic [INW-SW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[INW-1:SW];
          b_q <= b_in[INW-1:SW];
        end
      end
    end else begin : g_tail
      logic ov_q;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      always_ff @(posedge clk) begin
        if (reset) begin
          ov_q <= 1'b0;
        end else if (advance) begin
          ov_q <= a_in[SW-1] ^ b_in[SW-1] ^ sum[SW-1] ^ sum[SW];
        end
      end
    end
  end

  logic [WIDTH-1:0] res;

  assign res           = g_stage[STAGES-1].r_q;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.result    = res;
  assign bus.carry_out = g_stage[STAGES-1].c_q;
  assign bus.overflow  = g_stage[STAGES-1].g_tail.ov_q;
  assign bus.negative  = res[WIDTH-1];
  assign bus.zero      = (res == '0);
endmodule
